// File: rtl/ddr_axi_responder_pkg.sv
// Shared types and constants for the DDR AXI responder: FSM states,
// supported burst attributes and the address-channel payload.
package ddr_axi_responder_pkg;

  localparam int unsigned DATA_W  = 256;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned BEATS_W = LEN_W + 1;

  localparam logic [2:0] ASIZE_32B  = 3'd5;
  localparam logic [1:0] BURST_INCR = 2'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WRESP = 2'd2,
    READ  = 2'd3
  } state_t;

  typedef struct packed {
    logic             atype;
    logic [31:0]      aadr;
    logic [LEN_W-1:0] alen;
    logic [2:0]       asize;
    logic [1:0]       aburst;
  } areq_t;

  // Anything other than 32-byte INCR beats is flagged but still served as INCR.
  function automatic logic areq_bad(input areq_t r);
    return (r.asize != ASIZE_32B) || (r.aburst != BURST_INCR);
  endfunction

endpackage

// File: rtl/ddr_resp_mem.sv
// 256-bit word store with per-byte write enables and an asynchronous read port.
// Contents are deliberately never reset.
module ddr_resp_mem
  import ddr_axi_responder_pkg::*;
#(
  parameter int unsigned MEM_AW = 8
) (
  input  logic              AXI_CLK,
  input  logic [STRB_W-1:0] be,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [MEM_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] merged_c;

  // Merge enabled byte lanes into the current word, then write the whole word.
  always_comb begin
    merged_c = mem[waddr];
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (be[i]) merged_c[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge AXI_CLK) begin
    if (|be) mem[waddr] <= merged_c;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/ddr_axi_responder.sv
// AXI-style DDR memory responder: one shared address channel, INCR bursts of
// 32-byte beats into a 2^MEM_AW-word store, one outstanding transaction.
module ddr_axi_responder
  import ddr_axi_responder_pkg::*;
#(
  parameter int unsigned MEM_AW      = 8,
  parameter int unsigned AREADY_WAIT = 0
) (
  input  logic              AXI_CLK,
  input  logic              usr_rst,
  input  logic              DDR_AVALID,
  input  logic              DDR_ATYPE,
  input  logic [31:0]       DDR_AADR,
  input  logic [LEN_W-1:0]  DDR_ALEN,
  input  logic [2:0]        DDR_ASIZE,
  input  logic [1:0]        DDR_ABURST,
  output logic              DDR_AREADY,
  input  logic              DDR_WVALID,
  input  logic              DDR_WLAST,
  input  logic [DATA_W-1:0] DDR_WDATA,
  input  logic [STRB_W-1:0] DDR_WSTRB,
  output logic              DDR_WREADY,
  output logic              DDR_BVALID,
  input  logic              DDR_BREADY,
  output logic              DDR_RVALID,
  output logic              DDR_RLAST,
  output logic [DATA_W-1:0] DDR_RDATA,
  input  logic              DDR_RREADY,
  output logic              busy,
  output logic              err
);

  localparam int unsigned WAIT_W = $clog2(AREADY_WAIT + 2);

  state_t              state_q, state_d;
  logic [MEM_AW-1:0]   idx_q, idx_d;
  logic [BEATS_W-1:0]  beats_q, beats_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  logic                aready_q, wready_q, bvalid_q, rvalid_q, rlast_q, busy_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [STRB_W-1:0]   mem_be_c;
  logic [DATA_W-1:0]   mem_rdata_c;
  areq_t               areq_c;
  logic                last_c;
  logic                aadr_unused_c;

  assign areq_c = {DDR_ATYPE, DDR_AADR, DDR_ALEN, DDR_ASIZE, DDR_ABURST};
  assign last_c = (beats_q == BEATS_W'(1));
  assign aadr_unused_c = ^{areq_c.aadr[31:MEM_AW+5], areq_c.aadr[4:0]};

  // Next-state, burst bookkeeping and memory write enables.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    beats_d  = beats_q;
    wait_d   = '0;
    err_d    = err_q;
    mem_be_c = '0;
    case (state_q)
      IDLE: begin
        wait_d = (wait_q == WAIT_W'(AREADY_WAIT)) ? wait_q : wait_q + WAIT_W'(1);
        if (DDR_AVALID && aready_q) begin
          idx_d   = areq_c.aadr[MEM_AW+4:5];
          beats_d = BEATS_W'(areq_c.alen) + BEATS_W'(1);
          wait_d  = '0;
          if (areq_bad(areq_c)) err_d = 1'b1;
          state_d = areq_c.atype ? WRITE : READ;
        end
      end
      WRITE: begin
        if (DDR_WVALID && wready_q) begin
          mem_be_c = DDR_WSTRB;
          idx_d    = idx_q + MEM_AW'(1);
          beats_d  = beats_q - BEATS_W'(1);
          if (DDR_WLAST != last_c) err_d = 1'b1;
          if (last_c) state_d = WRESP;
        end
      end
      WRESP: begin
        if (bvalid_q && DDR_BREADY) state_d = IDLE;
      end
      READ: begin
        if (rvalid_q && DDR_RREADY) begin
          if (last_c) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + MEM_AW'(1);
            beats_d = beats_q - BEATS_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A burst cut short by reset must not leave a partial beat behind.
    if (usr_rst) mem_be_c = '0;
  end

  // State and registered outputs, all derived from the upcoming state.
  always_ff @(posedge AXI_CLK) begin
    if (usr_rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      beats_q  <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
      aready_q <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      beats_q  <= beats_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      aready_q <= (state_d == IDLE) && (wait_d == WAIT_W'(AREADY_WAIT));
      wready_q <= (state_d == WRITE);
      bvalid_q <= (state_d == WRESP);
      rvalid_q <= (state_d == READ);
      rlast_q  <= (state_d == READ) && (beats_d == BEATS_W'(1));
      busy_q   <= (state_d != IDLE);
      if (state_d == READ) rdata_q <= mem_rdata_c;
    end
  end

  ddr_resp_mem #(
    .MEM_AW (MEM_AW)
  ) u_mem (
    .AXI_CLK (AXI_CLK),
    .be      (mem_be_c),
    .waddr   (idx_q),
    .wdata   (DDR_WDATA),
    .raddr   (idx_d),
    .rdata_c (mem_rdata_c)
  );

  assign DDR_AREADY = aready_q;
  assign DDR_WREADY = wready_q;
  assign DDR_BVALID = bvalid_q;
  assign DDR_RVALID = rvalid_q;
  assign DDR_RLAST  = rlast_q;
  assign DDR_RDATA  = rdata_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ddr_axi_responder.sv
// Self-checking bench for ddr_axi_responder: table of directed bursts, random
// bursts against an array memory model, and hand-written reset/strobe cases.
module tb_ddr_axi_responder;

  localparam int unsigned MEM_AW      = 4;
  localparam int unsigned DEPTH       = 1 << MEM_AW;
  localparam int unsigned AREADY_WAIT = 1;

  typedef struct {
    bit          wr;
    int unsigned idx;
    int unsigned len;
    logic [2:0]  asize;
    logic [1:0]  aburst;
    int          wlast_at;   // -1: WLAST on the true last beat
    int          mode;       // 0 no stall, 1 RREADY 1,0,0 pattern, 2 random stalls
    bit          exp_err;
    bit          rst_before;
  } vec_t;

  logic         AXI_CLK = 1'b0;
  logic         usr_rst = 1'b1;
  logic         DDR_AVALID = 1'b0, DDR_ATYPE = 1'b0;
  logic [31:0]  DDR_AADR = '0;
  logic [7:0]   DDR_ALEN = '0;
  logic [2:0]   DDR_ASIZE = 3'd5;
  logic [1:0]   DDR_ABURST = 2'd1;
  logic         DDR_AREADY;
  logic         DDR_WVALID = 1'b0, DDR_WLAST = 1'b0;
  logic [255:0] DDR_WDATA = '0;
  logic [31:0]  DDR_WSTRB = '0;
  logic         DDR_WREADY, DDR_BVALID;
  logic         DDR_BREADY = 1'b0;
  logic         DDR_RVALID, DDR_RLAST;
  logic [255:0] DDR_RDATA;
  logic         DDR_RREADY = 1'b0;
  logic         busy, err;

  ddr_axi_responder #(.MEM_AW(MEM_AW), .AREADY_WAIT(AREADY_WAIT)) dut (
    .AXI_CLK(AXI_CLK), .usr_rst(usr_rst),
    .DDR_AVALID(DDR_AVALID), .DDR_ATYPE(DDR_ATYPE), .DDR_AADR(DDR_AADR),
    .DDR_ALEN(DDR_ALEN), .DDR_ASIZE(DDR_ASIZE), .DDR_ABURST(DDR_ABURST),
    .DDR_AREADY(DDR_AREADY),
    .DDR_WVALID(DDR_WVALID), .DDR_WLAST(DDR_WLAST), .DDR_WDATA(DDR_WDATA),
    .DDR_WSTRB(DDR_WSTRB), .DDR_WREADY(DDR_WREADY),
    .DDR_BVALID(DDR_BVALID), .DDR_BREADY(DDR_BREADY),
    .DDR_RVALID(DDR_RVALID), .DDR_RLAST(DDR_RLAST), .DDR_RDATA(DDR_RDATA),
    .DDR_RREADY(DDR_RREADY),
    .busy(busy), .err(err)
  );

  always #5 AXI_CLK = ~AXI_CLK;

  int unsigned  n_pass = 0;
  int unsigned  n_total = 0;
  logic [255:0] ref_mem [DEPTH];
  vec_t         vecs [14];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic do_reset();
    usr_rst = 1'b1;
    repeat (2) @(negedge AXI_CLK);
    usr_rst = 1'b0;
  endtask

  // Present the address and hold it until accepted; returns at the negedge after the handshake.
  task automatic send_addr(input vec_t v, output bit ok);
    int unsigned n = 0;
    logic [31:0] a;
    a = $urandom;
    a = (a & ~(32'(DEPTH - 1) << 5)) | (32'(v.idx) << 5);
    DDR_AVALID = 1'b1; DDR_ATYPE = v.wr; DDR_AADR = a;
    DDR_ALEN = 8'(v.len); DDR_ASIZE = v.asize; DDR_ABURST = v.aburst;
    while (DDR_AREADY !== 1'b1 && n < 20) begin
      @(negedge AXI_CLK);
      n++;
    end
    ok = (DDR_AREADY === 1'b1);
    checkb("addr_accept", DDR_AREADY, 1'b1);
    if (ok) @(negedge AXI_CLK);
    DDR_AVALID = 1'b0;
    if (ok) begin
      checkb("aready_low_busy", DDR_AREADY, 1'b0);
      checkb("busy_high", busy, 1'b1);
    end
  endtask

  task automatic finish_txn(input bit exp_err);
    checkb("busy_idle", busy, 1'b0);
    checkb("aready_wait", DDR_AREADY, 1'b0);
    checkb("err_flag", err, exp_err);
    @(negedge AXI_CLK);
    checkb("aready_up", DDR_AREADY, 1'b1);
  endtask

  task automatic write_burst(input vec_t v, input bit fixed, input logic [255:0] fdata,
                             input logic [31:0] fstrb, input bit rnd_strb);
    bit ok;
    int wl;
    logic [255:0] data;
    logic [31:0] strb;
    logic [MEM_AW-1:0] w;
    send_addr(v, ok);
    if (!ok) return;
    wl = (v.wlast_at < 0) ? int'(v.len) : v.wlast_at;
    for (int unsigned b = 0; b <= v.len; b++) begin
      if (v.mode == 2) begin
        while ($urandom_range(0, 2) == 0) begin
          DDR_WVALID = 1'b0;
          DDR_WDATA = {8{32'hDEAD_BEEF}};
          DDR_WSTRB = '1;
          checkb("wready_idle", DDR_WREADY, 1'b1);
          @(negedge AXI_CLK);
        end
      end
      for (int k = 0; k < 8; k++) data[32*k +: 32] = $urandom;
      strb = rnd_strb ? 32'($urandom) : 32'hFFFF_FFFF;
      if (fixed) begin
        data = fdata;
        strb = fstrb;
      end
      DDR_WVALID = 1'b1; DDR_WDATA = data; DDR_WSTRB = strb;
      DDR_WLAST = (int'(b) == wl);
      checkb("wready_beat", DDR_WREADY, 1'b1);
      w = MEM_AW'(v.idx + b);
      for (int i = 0; i < 32; i++) if (strb[i]) ref_mem[w][8*i +: 8] = data[8*i +: 8];
      @(negedge AXI_CLK);
    end
    DDR_WVALID = 1'b0; DDR_WLAST = 1'b0;
    checkb("wready_after_last", DDR_WREADY, 1'b0);
    checkb("bvalid_first", DDR_BVALID, 1'b1);
    repeat ($urandom_range(0, 2)) begin
      @(negedge AXI_CLK);
      checkb("bvalid_hold", DDR_BVALID, 1'b1);
    end
    DDR_BREADY = 1'b1;
    @(negedge AXI_CLK);
    DDR_BREADY = 1'b0;
    checkb("bvalid_clear", DDR_BVALID, 1'b0);
    finish_txn(v.exp_err);
  endtask

  task automatic read_burst(input vec_t v, output logic [255:0] first);
    bit ok;
    bit rr;
    int unsigned b = 0, step = 0;
    logic [MEM_AW-1:0] w;
    first = '0;
    send_addr(v, ok);
    if (!ok) return;
    while (b <= v.len && step < 200) begin
      w = MEM_AW'(v.idx + b);
      if (b == 0) first = DDR_RDATA;
      checkb("rvalid", DDR_RVALID, 1'b1);
      check("rdata", DDR_RDATA, ref_mem[w]);
      checkb("rlast", DDR_RLAST, b == v.len);
      case (v.mode)
        1:       rr = (step % 3 == 0);
        2:       rr = 1'($urandom_range(0, 1));
        default: rr = 1'b1;
      endcase
      DDR_RREADY = rr;
      step++;
      @(negedge AXI_CLK);
      if (rr) b++;
    end
    DDR_RREADY = 1'b0;
    checkb("read_done", b > v.len, 1'b1);
    checkb("rvalid_clear", DDR_RVALID, 1'b0);
    checkb("rlast_clear", DDR_RLAST, 1'b0);
    finish_txn(v.exp_err);
  endtask

  task automatic run_vec(input vec_t v, input bit rnd_strb);
    logic [255:0] dummy;
    if (v.rst_before) do_reset();
    if (v.wr) write_burst(v, 1'b0, '0, '0, rnd_strb);
    else read_burst(v, dummy);
  endtask

  initial begin
    vec_t v;
    logic [255:0] got;
    bit ok;
    int unsigned n;

    //          wr idx len asize  burst wl mode err rst
    vecs[0]  = '{1'b1, 0, 15, 3'd5, 2'd1, -1, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2, 3,  3'd5, 2'd1, -1, 0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2, 3,  3'd5, 2'd1, -1, 0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 15, 1, 3'd5, 2'd1, -1, 0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 15, 1, 3'd5, 2'd1, -1, 0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 0, 0,  3'd5, 2'd1, -1, 0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 0, 7,  3'd5, 2'd1, -1, 1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 3, 3,  3'd5, 2'd1, -1, 2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3, 3,  3'd5, 2'd1, -1, 2, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4, 3,  3'd5, 2'd1, 1,  0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4, 3,  3'd5, 2'd1, -1, 0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 6, 3,  3'd4, 2'd1, -1, 0, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 8, 1,  3'd5, 2'd2, -1, 0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 8, 1,  3'd5, 2'd1, -1, 0, 1'b1, 1'b0};

    repeat (2) @(negedge AXI_CLK);
    checkb("rst_aready", DDR_AREADY, 1'b0);
    checkb("rst_wready", DDR_WREADY, 1'b0);
    checkb("rst_bvalid", DDR_BVALID, 1'b0);
    checkb("rst_rvalid", DDR_RVALID, 1'b0);
    checkb("rst_rlast", DDR_RLAST, 1'b0);
    check("rst_rdata", DDR_RDATA, '0);
    checkb("rst_busy", busy, 1'b0);
    checkb("rst_err", err, 1'b0);
    usr_rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b0);

    // Partial strobe over an all-ones word: only the low 16 byte lanes take the zeros.
    v = '{1'b1, 5, 0, 3'd5, 2'd1, -1, 0, 1'b0, 1'b0};
    write_burst(v, 1'b1, '1, 32'hFFFF_FFFF, 1'b0);
    write_burst(v, 1'b1, '0, 32'h0000_FFFF, 1'b0);
    v.wr = 1'b0;
    read_burst(v, got);
    check("strb_merge", got, {{128{1'b1}}, 128'b0});

    for (int t = 0; t < 30; t++) begin
      v.wr = 1'($urandom_range(0, 1));
      v.idx = $urandom_range(0, DEPTH - 1);
      v.len = $urandom_range(0, 15);
      v.asize = 3'd5; v.aburst = 2'd1; v.wlast_at = -1;
      v.mode = 2; v.exp_err = 1'b0; v.rst_before = 1'b0;
      run_vec(v, 1'b1);
    end

    for (int i = 9; i < 14; i++) run_vec(vecs[i], 1'b0);

    // Reset while the second beat of a 4-beat read is on the bus.
    v = '{1'b0, 0, 3, 3'd5, 2'd1, -1, 0, 1'b0, 1'b0};
    send_addr(v, ok);
    check("mid_rdata0", DDR_RDATA, ref_mem[MEM_AW'(0)]);
    DDR_RREADY = 1'b1;
    @(negedge AXI_CLK);
    check("mid_rdata1", DDR_RDATA, ref_mem[MEM_AW'(1)]);
    usr_rst = 1'b1;
    @(negedge AXI_CLK);
    checkb("mid_rst_rvalid", DDR_RVALID, 1'b0);
    checkb("mid_rst_rlast", DDR_RLAST, 1'b0);
    checkb("mid_rst_busy", busy, 1'b0);
    checkb("mid_rst_err", err, 1'b0);
    checkb("mid_rst_aready", DDR_AREADY, 1'b0);
    check("mid_rst_rdata", DDR_RDATA, '0);
    usr_rst = 1'b0;
    DDR_RREADY = 1'b0;
    n = 0;
    while (DDR_AREADY !== 1'b1 && n < 8) begin
      @(negedge AXI_CLK);
      n++;
    end
    checkb("post_rst_aready", DDR_AREADY, 1'b1);
    v = '{1'b1, 9, 2, 3'd5, 2'd1, -1, 0, 1'b0, 1'b0};
    write_burst(v, 1'b0, '0, '0, 1'b0);
    v.wr = 1'b0;
    read_burst(v, got);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
